// File: rtl/ghash_ctrl.sv
// GHASH sequencing controller: accumulator clear/load, multiplier start/done, length block.
// Define GHASH_CTRL_TIMEOUT_EN to add the mul_done watchdog and the ERR state.
module ghash_ctrl #(
  parameter int CNT_W = 32
`ifdef GHASH_CTRL_TIMEOUT_EN
  ,
  parameter int TIMEOUT = 64
`endif
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         start_empty,
  input  logic         blk_valid,
  input  logic         blk_is_aad,
  input  logic         blk_last,
  output logic         blk_ready,
  output logic         mul_start,
  input  logic         mul_done,
  output logic         op_sel,
  output logic         ac_en,
  output logic         clr_ac,
  output logic [127:0] len_blk,
  output logic         tag_valid,
  input  logic         tag_ready,
  output logic         busy,
  output logic         err
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_CLEAR    = 3'd1;
  localparam logic [2:0] S_WAIT_BLK = 3'd2;
  localparam logic [2:0] S_MUL      = 3'd3;
  localparam logic [2:0] S_MUL_LEN  = 3'd4;
  localparam logic [2:0] S_DONE     = 3'd5;
  localparam logic [2:0] S_ERR      = 3'd6;

  logic [2:0]       state;
  logic [2:0]       nxt;
  logic [CNT_W-1:0] aad_cnt;
  logic [CNT_W-1:0] ct_cnt;
  logic             last_q;
  logic             empty_q;
  logic             first_q;
  logic             err_q;
  logic             in_mul;
  logic             tmo;
  logic [63:0]      aad_bits;
  logic [63:0]      ct_bits;

  assign in_mul = (state == S_MUL) || (state == S_MUL_LEN);

`ifdef GHASH_CTRL_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT + 1);
  logic [WW-1:0] wcnt;

  // wcnt is 0 in the first cycle of a MUL/MUL_LEN visit
  assign tmo = in_mul && !mul_done && (wcnt == WW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt <= '0;
    end else if (nxt != state) begin
      wcnt <= '0;
    end else if (in_mul) begin
      wcnt <= wcnt + 1'b1;
    end
  end
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:     if (start) nxt = S_CLEAR;
      S_CLEAR:    nxt = empty_q ? S_MUL_LEN : S_WAIT_BLK;
      S_WAIT_BLK: if (blk_valid) nxt = S_MUL;
      S_MUL: begin
        if (mul_done) nxt = last_q ? S_MUL_LEN : S_WAIT_BLK;
        else if (tmo) nxt = S_ERR;
      end
      S_MUL_LEN: begin
        if (mul_done) nxt = S_DONE;
        else if (tmo) nxt = S_ERR;
      end
      S_DONE:     if (tag_ready) nxt = S_IDLE;
`ifdef GHASH_CTRL_TIMEOUT_EN
      S_ERR:      nxt = S_ERR;
`endif
      default:    nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      aad_cnt <= '0;
      ct_cnt  <= '0;
      last_q  <= 1'b0;
      empty_q <= 1'b0;
      first_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= nxt;
      // MUL -> MUL_LEN is a new entry and gets its own start pulse
      first_q <= (nxt != state) &&
                 ((nxt == S_MUL) || (nxt == S_MUL_LEN));
      if (state == S_IDLE && start) begin
        aad_cnt <= '0;
        ct_cnt  <= '0;
        err_q   <= 1'b0;
        empty_q <= start_empty;
      end
      if (state == S_WAIT_BLK && blk_valid) begin
        last_q <= blk_last;
        if (blk_is_aad) begin
          if (&aad_cnt) err_q <= 1'b1;
          else aad_cnt <= aad_cnt + 1'b1;
        end else begin
          if (&ct_cnt) err_q <= 1'b1;
          else ct_cnt <= ct_cnt + 1'b1;
        end
      end
      if (tmo) err_q <= 1'b1;
    end
  end

  assign aad_bits  = 64'(aad_cnt) << 7;
  assign ct_bits   = 64'(ct_cnt) << 7;
  assign len_blk   = {aad_bits, ct_bits};
  assign blk_ready = (state == S_WAIT_BLK);
  assign mul_start = in_mul && first_q;
  assign ac_en     = in_mul && mul_done;
  assign op_sel    = (state == S_MUL_LEN);
  assign clr_ac    = (state == S_CLEAR);
  assign tag_valid = (state == S_DONE);
  assign busy      = (state != S_IDLE);
  assign err       = err_q;

endmodule

// File: tb/tb_ghash_ctrl.sv
// Scoreboard bench for ghash_ctrl: expected multiplier ops and tags are queued
// by the stimulus and popped by a negedge monitor.
module tb_ghash_ctrl;
  localparam int CW  = 3;
  localparam int MAX = (1 << CW) - 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         start_empty = 1'b0;
  logic         blk_valid = 1'b0;
  logic         blk_is_aad = 1'b0;
  logic         blk_last = 1'b0;
  logic         blk_ready;
  logic         mul_start;
  logic         mul_done;
  logic         op_sel;
  logic         ac_en;
  logic         clr_ac;
  logic [127:0] len_blk;
  logic         tag_valid;
  logic         tag_ready = 1'b0;
  logic         busy;
  logic         err;

  logic done_r = 1'b0;
  logic inj = 1'b0;
  logic lat0 = 1'b0;
  logic hold = 1'b0;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int len_done_cyc = -10;
  logic tv_prev = 1'b0;

  bit           exp_op[$];
  logic [127:0] exp_len[$];
  logic [127:0] exp_tag[$];
  bit           m_op;
  logic [127:0] m_len;

  always #5 clk = ~clk;

  // multiplier model: 1-cycle latency, optional same-cycle done or withheld done
  assign mul_done = (lat0 & mul_start) | done_r | inj;
  always @(posedge clk) done_r <= mul_start & ~lat0 & ~hold;

  ghash_ctrl #(.CNT_W(CW)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .start_empty(start_empty),
    .blk_valid(blk_valid),
    .blk_is_aad(blk_is_aad),
    .blk_last(blk_last),
    .blk_ready(blk_ready),
    .mul_start(mul_start),
    .mul_done(mul_done),
    .op_sel(op_sel),
    .ac_en(ac_en),
    .clr_ac(clr_ac),
    .len_blk(len_blk),
    .tag_valid(tag_valid),
    .tag_ready(tag_ready),
    .busy(busy),
    .err(err)
  );

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] lenv(int a, int c);
    logic [63:0] x;
    logic [63:0] y;
    x = 64'(a) * 64'd128;
    y = 64'(c) * 64'd128;
    return {x, y};
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (mul_start) begin
        if (exp_op.size() == 0) begin
          chk("unexpected_mul_start", 128'(mul_start), 128'(0));
        end else begin
          m_op  = exp_op.pop_front();
          m_len = exp_len.pop_front();
          chk("mul_op_sel", 128'(op_sel), 128'(m_op));
          if (m_op) chk("len_blk", len_blk, m_len);
        end
      end
      if (ac_en || clr_ac)
        chk("ac_clr_excl", 128'(ac_en & clr_ac), 128'(0));
      if (ac_en && op_sel) len_done_cyc = cyc;
      if (tag_valid && !tv_prev)
        chk("tag_latency", 128'(cyc - len_done_cyc), 128'(1));
      if (tag_valid && tag_ready) begin
        if (exp_tag.size() == 0) begin
          chk("unexpected_tag", 128'(tag_valid), 128'(0));
        end else begin
          m_len = exp_tag.pop_front();
          chk("tag_len_blk", len_blk, m_len);
        end
      end
    end
    tv_prev = tag_valid;
  end

  task automatic do_start(input bit e);
    @(posedge clk); #1;
    start = 1'b1;
    start_empty = e;
    @(posedge clk); #1;
    start = 1'b0;
    start_empty = 1'b0;
    if (e) begin
      exp_op.push_back(1'b1);
      exp_len.push_back('0);
      exp_tag.push_back('0);
    end
    @(negedge clk);
    chk("start_clr_ac", 128'({clr_ac, busy}), 128'(2'b11));
  endtask

  task automatic send_blk(input bit aad, input bit last, input logic [127:0] l);
    exp_op.push_back(1'b0);
    exp_len.push_back('0);
    if (last) begin
      exp_op.push_back(1'b1);
      exp_len.push_back(l);
      exp_tag.push_back(l);
    end
    @(posedge clk); #1;
    blk_valid = 1'b1;
    blk_is_aad = aad;
    blk_last = last;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (blk_ready) break;
    end
    chk("blk_ready_wait", 128'(blk_ready), 128'(1));
    @(posedge clk); #1;
    blk_valid = 1'b0;
    blk_is_aad = 1'b0;
    blk_last = 1'b0;
    @(negedge clk);
    chk("hs_to_mul_start", 128'(mul_start), 128'(1));
  endtask

  task automatic msg(input int na, input int nc);
    logic [127:0] l;
    l = lenv(na > MAX ? MAX : na, nc > MAX ? MAX : nc);
    for (int i = 0; i < na + nc; i++)
      send_blk(i < na, i == na + nc - 1, l);
  endtask

  task automatic get_tag(input int hold_cyc);
    tag_ready = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tag_valid) break;
    end
    chk("tag_valid_wait", 128'(tag_valid), 128'(1));
    for (int i = 0; i < hold_cyc; i++) begin
      @(negedge clk);
      chk("tag_hold", 128'({tag_valid, busy}), 128'(2'b11));
    end
    @(posedge clk); #1;
    tag_ready = 1'b1;
    @(posedge clk); #1;
    tag_ready = 1'b0;
    @(negedge clk);
    chk("idle_after_tag", 128'(busy), 128'(0));
  endtask

  initial begin
    #1;
    chk("reset_outputs",
        128'({busy, blk_ready, mul_start, ac_en, clr_ac, op_sel, tag_valid, err}),
        128'(0));
    chk("reset_len", len_blk, '0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // mixed message with WAIT_BLK and tag backpressure
    do_start(1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_wait_blk", 128'({blk_ready, mul_start}), 128'(2'b10));
    end
    msg(2, 3);
    get_tag(5);

    // empty message
    do_start(1'b1);
    get_tag(0);

    // protocol corners
    do_start(1'b0);
    @(posedge clk); #1 inj = 1'b1;
    @(negedge clk);
    chk("done_in_wait", 128'({ac_en, blk_ready}), 128'(2'b01));
    @(posedge clk); #1 inj = 1'b0;
    lat0 = 1'b1;
    send_blk(1'b1, 1'b0, '0);
    chk("same_cycle_ac_en", 128'(ac_en), 128'(1));
    @(posedge clk); #1 lat0 = 1'b0;
    @(negedge clk);
    chk("wait_after_done", 128'(blk_ready), 128'(1));
    send_blk(1'b0, 1'b1, lenv(1, 1));
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    get_tag(0);

    // counter saturation
    do_start(1'b0);
    msg(0, MAX + 1);
    get_tag(0);
    chk("sat_err", 128'(err), 128'(1));
    do_start(1'b1);
    chk("err_cleared", 128'(err), 128'(0));
    get_tag(0);

    // asynchronous reset in MUL
    hold = 1'b1;
    do_start(1'b0);
    send_blk(1'b1, 1'b0, '0);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_mul",
        128'({busy, blk_ready, mul_start, ac_en, clr_ac, op_sel, tag_valid, err}),
        128'(0));
    chk("rst_mid_len", len_blk, '0);
    hold = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    do_start(1'b1);
    get_tag(0);

`ifdef GHASH_CTRL_TIMEOUT_EN
    begin
      int k;
      k = 0;
      hold = 1'b1;
      do_start(1'b0);
      send_blk(1'b0, 1'b0, '0);
      for (int i = 1; i <= 100; i++) begin
        @(negedge clk);
        if (err) begin
          k = i;
          break;
        end
      end
      chk("timeout_cycles", 128'(k), 128'(64));
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      @(negedge clk);
      chk("err_ignores_start", 128'({busy, clr_ac, err}), 128'(3'b101));
      hold = 1'b0;
      #2 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("err_left_by_rst", 128'({busy, err}), 128'(0));
    end
`endif

    repeat (2) @(negedge clk);
    chk("mul_queue_empty", 128'(exp_op.size()), 128'(0));
    chk("tag_queue_empty", 128'(exp_tag.size()), 128'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1);
  end

endmodule

// File: doc/ghash_ctrl.md
# ghash_ctrl

Sequencing controller for the GHASH datapath: drives the 128-bit accumulator register's clear and load enables, a shared GF(2^128) multiplier through a start/done handshake, and the XOR-operand select. Accepts a stream of full 128-bit AAD and ciphertext blocks, then appends the GCM length block. Presents the final accumulator value as a tag via a valid/ready handshake. Sits between the GCM top-level sequencer and the accumulator/multiplier datapath.

## Interface
- CNT_W, 32, width of the AAD and ciphertext block counters (1..57).
- TIMEOUT, 64, maximum cycles to wait for mul_done; used only with the Configuration macro.

- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin a new GHASH computation; sampled only in IDLE.
- start_empty  input  1  qualifies start: message has zero blocks; go straight to the length block.
- blk_valid  input  1  data block available on the datapath.
- blk_is_aad  input  1  1 = current block is AAD, 0 = ciphertext; sampled on handshake.
- blk_last  input  1  current block is the final data block; sampled on handshake.
- blk_ready  output  1  controller accepts a block this cycle.
- mul_start  output  1  one-cycle pulse; multiplier latches (acc XOR operand) and H.
- mul_done  input  1  multiplier result valid this cycle.
- op_sel  output  1  XOR operand select: 0 = data block, 1 = len_blk.
- ac_en  output  1  accumulator load enable.
- clr_ac  output  1  accumulator synchronous clear.
- len_blk  output  128  {aad_bits[63:0], ct_bits[63:0]}, bits = block count × 128.
- tag_valid  output  1  accumulator holds the final tag.
- tag_ready  input  1  consumer accepts the tag.
- busy  output  1  state is not IDLE.
- err  output  1  sticky error flag; cleared by rst or by accepted start.

## Operation
- States: IDLE, CLEAR, WAIT_BLK, MUL, MUL_LEN, DONE (plus ERR with the macro).
- IDLE, start=1: clear both counters and err; go to CLEAR. A start while not in IDLE is ignored.
- CLEAR: clr_ac=1 for exactly one cycle. Next state is MUL_LEN if start_empty was 1 at start; otherwise WAIT_BLK.
- WAIT_BLK: blk_ready=1, op_sel=0. On blk_valid=1, increment the AAD or CT counter per blk_is_aad, latch blk_last, and go to MUL.
- MUL: mul_start=1 in the first cycle only. ac_en = mul_done (combinational), so the accumulator captures the result on that edge. On mul_done, go to MUL_LEN if the latched last flag is 1; otherwise go to WAIT_BLK.
- MUL_LEN: op_sel=1, mul_start=1 in the first cycle only, ac_en = mul_done. On mul_done, go to DONE.
- DONE: tag_valid=1 until tag_ready=1, then go to IDLE.
- Counters saturate at all-ones and set err; the sequence continues.
- len_blk fields are zero-extended counts shifted left by 7. Only full blocks are supported.
- mul_done outside MUL/MUL_LEN is ignored. blk_valid outside WAIT_BLK is not accepted (blk_ready=0).
- ac_en and clr_ac are never asserted in the same cycle.

## Timing
- Reset values: state IDLE, counters 0, len_blk 0; all 1-bit outputs are 0.
- Reset mid-operation returns to IDLE immediately. No tag is produced and the partial accumulator is abandoned.
- start to clr_ac: 1 cycle, since CLEAR is entered on the next edge.
- Block handshake to mul_start: 1 cycle.
- mul_done to blk_ready (next block): 1 cycle.
- mul_done (length block) to tag_valid: 1 cycle.
- Minimum per block with a 1-cycle multiplier: 3 cycles (WAIT_BLK, then MUL with mul_start, then mul_done).
- mul_done asserted in the same cycle as mul_start is legal and is accepted.
- op_sel is stable for the whole MUL/MUL_LEN residency.

## Configuration
- GHASH_CTRL_TIMEOUT_EN defined:
  - A wait counter runs in MUL/MUL_LEN and resets on state entry.
  - If mul_done has not arrived after TIMEOUT cycles: go to ERR and set err=1. ERR has all strobes 0 and busy=1.
  - ERR is exited to IDLE only by rst.
- Undefined: no wait counter and no ERR state; the controller waits for mul_done indefinitely.

## Test plan
- Reset: rst pulsed mid-MUL.
  - Response: all outputs go to 0 asynchronously; state returns to IDLE; a following start behaves normally.
- Mixed message: 2 AAD and 3 CT blocks, 1-cycle multiplier.
  - Response: 5 data mul_start pulses plus 1 length pulse.
  - len_blk = {64'd256, 64'd384}.
  - tag_valid 1 cycle after the last mul_done.
- Empty message: start with start_empty=1.
  - Response: clr_ac, then MUL_LEN directly with len_blk=0; exactly 1 mul_start; tag_valid follows.
- Backpressure:
  - blk_valid held 0 for 10 cycles in WAIT_BLK. Response: blk_ready stays 1, no mul_start.
  - tag_ready held 0 for 5 cycles. Response: tag_valid stays high; IDLE is reached the cycle after tag_ready=1.
- Protocol corners:
  - start during MUL: ignored.
  - mul_done pulsed in WAIT_BLK: no ac_en.
  - mul_done in the same cycle as mul_start: ac_en in that cycle.
- Timeout (macro on, TIMEOUT=64): mul_done withheld.
  - Response: err=1 and ERR entered exactly 64 cycles after mul_start; start is ignored until rst.
